dram_ctrl: RTL and testbench

Data-memory responder for the pipelined CPU. It accepts load and store requests from the memory stage and drives a synchronous single-port 32-bit data RAM with one-cycle read latency. Sub-word stores are turned into an internal read-modify-write, and loads return sign- or zero-extended data. The block sits between the memory stage and the DRAM macro, and its `req_ready` is the source of the memory-stage stall.

---
 rtl/dram_pkg.sv | 35 +++
 rtl/dram_ctrl_store_merge.sv | 40 ++++
 rtl/dram_ctrl.sv | 120 ++++++++++++
 tb/tb_dram_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: size codes, FSM state encoding and request record shared by the
// data-RAM controller and its lane-merge helper.
package dram_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned DEF_ADDR_W = 14;
   localparam int unsigned RD_LAT     = 1;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_DATA  = 3'd2,
      ST_WRITE    = 3'd3,
      ST_ERR      = 3'd4
   } state_t;

   // Request fields captured on accept; the requester may change req_* afterwards.
   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic              is_unsigned;
      logic [1:0]        lane;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // The reserved size code 11 behaves as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return (size == SIZE_W) || (size == 2'b11);
   endfunction

endpackage

// File: rtl/dram_ctrl_store_merge.sv
// store_merge: lane select for sub-word accesses; produces the read-modify-write
// word and the sign/zero-extended load result from the same lane.
module store_merge
   import dram_pkg::*;
(
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        size,
   input  logic [1:0]        lane,
   input  logic              is_unsigned,
   output logic [DATA_W-1:0] merged,
   output logic [DATA_W-1:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      merged    = old_word;
      load_data = old_word;
      byte_v    = old_word[{lane, 3'b000} +: 8];
      half_v    = old_word[{lane[1], 4'b0000} +: 16];
      case (size)
         SIZE_B: begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
            load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
         end
         SIZE_H: begin
            // addr[0] never selects a half lane; misalignment is handled upstream.
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
         end
         default: begin
            merged    = wdata;
            load_data = old_word;
         end
      endcase
   end

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: load/store responder driving a single-port RAM with 1-cycle read latency.
// Define DRAM_ALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err.
module dram_ctrl
   import dram_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state;
   req_t              req_q;
   logic              misaligned_c;
   logic [DATA_W-1:0] merged_c;
   logic [DATA_W-1:0] load_c;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DRAM_ALIGN_CHECK_EN
   assign misaligned_c = ((req_size == SIZE_H) && req_addr[0])
                       || (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned_c = 1'b0;
`endif

   store_merge u_store_merge (
      .old_word    (ram_rdata),
      .wdata       (req_q.wdata),
      .size        (req_q.size),
      .lane        (req_q.lane),
      .is_unsigned (req_q.is_unsigned),
      .merged      (merged_c),
      .load_data   (load_c)
   );

   // Load data is only meaningful in the cycle the RAM returns it.
   assign rsp_rdata = ((state == ST_RD_DATA) && !req_q.we) ? load_c : '0;

   // Controller FSM; every output except rsp_rdata is set for the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_q     <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q     <= '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                                 lane: req_addr[1:0], wdata: req_wdata};
                  ram_addr  <= req_addr[ADDR_W+1:2];
                  req_ready <= 1'b0;
                  if (misaligned_c) begin
                     state     <= ST_ERR;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && is_word(req_size)) begin
                     state     <= ST_WRITE;
                     ram_en    <= 1'b1;
                     ram_we    <= 1'b1;
                     ram_wdata <= req_wdata;
                     rsp_valid <= 1'b1;
                  end else begin
                     state  <= ST_RD_ISSUE;
                     ram_en <= 1'b1;
                  end
               end
            end
            ST_RD_ISSUE: begin
               state     <= ST_RD_DATA;
               rsp_valid <= !req_q.we;
            end
            ST_RD_DATA: begin
               if (req_q.we) begin
                  state     <= ST_WRITE;
                  ram_wdata <= merged_c;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b1;
                  rsp_valid <= 1'b1;
               end else begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed + randomized scoreboard bench for dram_ctrl against a
// byte-lane arithmetic model of memory; the RAM macro is modelled here too.
module tb_dram_ctrl;
   import dram_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_en, ram_we;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   logic [31:0] ram     [0:16383];
   logic [31:0] ref_mem [0:16383];
   exp_t        exp_q[$];
   int          cyc, ram_acc, exp_acc;
   int          vectors, miscompares;

   dram_ctrl #(.ADDR_W(14)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM macro: one-cycle registered read, write on ram_en & ram_we.
   initial ram_acc = 0;
   always @(posedge clk) begin
      if (ram_en) begin
         ram_acc <= ram_acc + 1;
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: memory as bytes-in-words, lanes picked with shifts and masks.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output int n_acc);
      exp_t        e;
      int          nbytes, off, idx;
      logic [31:0] mask, v;
      logic        mis;
      idx    = int'(addr[15:2]);
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      off    = (nbytes == 1) ? int'(addr[1:0]) : (nbytes == 2) ? (addr[1] ? 2 : 0) : 0;
      mask   = 32'((64'd1 << (8 * nbytes)) - 64'd1);
`ifdef DRAM_ALIGN_CHECK_EN
      mis = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      e.err = 1'b0;
      e.rdata = 32'd0;
      if (mis) begin
         e.err = 1'b1;
         e.lat = 1;
         n_acc = 0;
      end else if (we) begin
         ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
         e.lat = (nbytes == 4) ? 1 : 3;
         n_acc = (nbytes == 4) ? 1 : 2;
      end else begin
         v = (ref_mem[idx] >> (8 * off)) & mask;
         if (!uns && nbytes < 4 && v > (mask >> 1)) v = v | ~mask;
         e.rdata = v;
         e.lat = 2;
         n_acc = 1;
      end
      e.acc = 0;
      return e;
   endfunction

   // Present a request at a negedge, wait (bounded) for accept, return at the
   // negedge after the accept edge with req_valid dropped.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit use_const, input logic [31:0] const_rd,
                        input bit track, output int acc);
      exp_t e;
      int   na, waitc;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      waitc = 0;
      while (!req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         acc = cyc;
         return;
      end
      acc = cyc;
      if (track) begin
         e = model(we, size, uns, addr, wdata, na);
         if (use_const) e.rdata = const_rd;
         e.acc = acc;
         exp_q.push_back(e);
         exp_acc += na;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
      check({tag, "_ram_en"},    32'(ram_en),    32'd0);
      check({tag, "_ram_we"},    32'(ram_we),    32'd0);
      check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
      check({tag, "_ram_wdata"}, ram_wdata,      32'd0);
   endtask

   // Monitor: every rsp_valid pops the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int          acc, acc2, waitc;
      logic [31:0] a;
      vectors = 0; miscompares = 0; exp_acc = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_rst");

      // Fill the low 64 words with random data through the DUT.
      for (int i = 0; i < 64; i++)
         issue(1'b1, SIZE_W, 1'b0, {16'($urandom), 8'd0, 6'(i), 2'b00}, $urandom, 0, 32'd0, 1, acc);

      // Word store then word load of 0x10.
      issue(1'b1, SIZE_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'd0, 1, acc);
      check("wst_ram_we", 32'(ram_en & ram_we), 32'd1);
      check("wst_ram_addr", 32'(ram_addr), 32'd4);
      check("wst_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
      issue(1'b0, SIZE_W, 1'b0, 32'h0000_0010, 32'd0, 1, 32'hDEAD_BEEF, 1, acc);
      check("wld_ram_rd", 32'({ram_en, ram_we}), 32'b10);
      check("wld_ram_addr", 32'(ram_addr), 32'd4);

      // Byte store 0xAB into 0x11223344 at 0x12.
      issue(1'b1, SIZE_W, 1'b0, 32'h0000_0010, 32'h1122_3344, 0, 32'd0, 1, acc);
      issue(1'b1, SIZE_B, 1'b0, 32'h0000_0012, 32'h0000_00AB, 0, 32'd0, 1, acc);
      check("bst_t1_read", 32'({ram_en, ram_we}), 32'b10);
      check("bst_t1_addr", 32'(ram_addr), 32'd4);
      @(negedge clk);
      check("bst_t2_idle_ram", 32'(ram_en), 32'd0);
      @(negedge clk);
      check("bst_t3_write", 32'({ram_en, ram_we}), 32'b11);
      check("bst_t3_wdata", ram_wdata, 32'h11AB_3344);
      @(negedge clk);

      // Extension from 0x80FF7F01 at 0x20.
      issue(1'b1, SIZE_W, 1'b0, 32'h0000_0020, 32'h80FF_7F01, 0, 32'd0, 1, acc);
      issue(1'b0, SIZE_B, 1'b0, 32'h0000_0023, 32'd0, 1, 32'hFFFF_FF80, 1, acc);
      issue(1'b0, SIZE_B, 1'b1, 32'h0000_0023, 32'd0, 1, 32'h0000_0080, 1, acc);
      issue(1'b0, SIZE_H, 1'b0, 32'h0000_0022, 32'd0, 1, 32'hFFFF_80FF, 1, acc);
      issue(1'b0, SIZE_H, 1'b1, 32'h0000_0020, 32'd0, 1, 32'h0000_7F01, 1, acc);

      // req_valid held high across a sub-word store.
      issue(1'b1, SIZE_H, 1'b0, 32'h0000_0026, 32'h0000_1234, 0, 32'd0, 1, acc);
      req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0;
      req_addr = 32'h0000_0024; req_wdata = 32'd0;
      for (int k = 1; k <= 3; k++) begin
         check("hold_req_ready_low", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      issue(1'b0, SIZE_W, 1'b0, 32'h0000_0024, 32'd0, 0, 32'd0, 1, acc2);
      check("hold_accept_gap", 32'(acc2 - acc), 32'd4);
      @(negedge clk);

      // Misaligned word load at 0x06.
      issue(1'b1, SIZE_W, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 0, 32'd0, 1, acc);
`ifdef DRAM_ALIGN_CHECK_EN
      issue(1'b0, SIZE_W, 1'b0, 32'h0000_0006, 32'd0, 1, 32'd0, 1, acc);
      check("mis_ram_en", 32'(ram_en), 32'd0);
`else
      issue(1'b0, SIZE_W, 1'b0, 32'h0000_0006, 32'd0, 1, 32'hCAFE_F00D, 1, acc);
      check("mis_ram_en", 32'(ram_en), 32'd1);
      check("mis_ram_addr", 32'(ram_addr), 32'd1);
`endif
      @(negedge clk);

      // Reset during RD_DATA of a half store: the merge write is lost.
      issue(1'b1, SIZE_W, 1'b0, 32'h0000_0030, 32'h0123_4567, 0, 32'd0, 1, acc);
      issue(1'b1, SIZE_H, 1'b0, 32'h0000_0032, 32'h0000_5A5A, 0, 32'd0, 0, acc);
      exp_acc += 1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_no_we", 32'(ram_we), 32'd0);
      end
      check("midrst_ram_word", ram[12], 32'h0123_4567);

      // Randomized traffic with occasional idle gaps.
      for (int n = 0; n < 300; n++) begin
         a = {16'($urandom), 8'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
         issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0, 32'd0, 1, acc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      waitc = 0;
      while (exp_q.size() != 0 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      repeat (2) @(negedge clk);
      check("pending_responses", 32'(exp_q.size()), 32'd0);
      check("ram_access_count", 32'(ram_acc), 32'(exp_acc));
      for (int i = 0; i < 64; i++)
         check("ram_word", ram[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
